// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze constants, solver direction codes and arbiter state encoding
package maze_pkg;

  localparam int ADDR_W   = 6;
  localparam int MAZE_MAX = 63;

  typedef enum logic [1:0] {
    DIR_S = 2'd0,
    DIR_E = 2'd1,
    DIR_N = 2'd2,
    DIR_V = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_any
);
  import maze_pkg::*;

  // First active request at or above the pointer, wrapping past the top
  always_comb begin
    int w_idx;
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_idx[PTR_W-1:0]]) begin
        o_grant[w_idx[PTR_W-1:0]] = 1'b1;
        o_any                     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// rtl/maze_mem_arbiter.sv - round-robin maze memory port arbiter with per-requester lock (optional stats: MAZE_ARB_STATS_EN)
module maze_mem_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = maze_pkg::ADDR_W,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_row,
  input  logic [NUM_REQ*ADDR_W-1:0] req_col,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_data,
  output logic [ADDR_W-1:0]         row,
  output logic [ADDR_W-1:0]         col,
  output logic                      maze_oe,
  output logic                      maze_we,
  input  logic                      maze_in
`ifdef MAZE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grants,
  output logic [15:0]               stat_conflicts,
  output logic [15:0]               stat_forced
`endif
);
  import maze_pkg::*;

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t         r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic               r_owner_vld;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_we;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ADDR_W-1:0]  r_row;
  logic [ADDR_W-1:0]  r_col;
  logic               r_oe;
  logic               r_mwe;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_data;

  logic               w_idle;
  logic               w_owner_req;
  logic               w_owner_drop;
  logic               w_rr_any;
  logic               w_accept;
  logic               w_lock;
  logic               w_we;
  logic               w_forced;
  logic [PTR_W-1:0]   w_pick_ptr;
  logic [PTR_W-1:0]   w_gidx;
  logic [NUM_REQ-1:0] w_rr_grant;
  logic [NUM_REQ-1:0] w_grant;
  logic [ADDR_W-1:0]  w_row;
  logic [ADDR_W-1:0]  w_col;
  logic [HOLD_W-1:0]  w_hold_nxt;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  // A grant is only possible while idle and out of reset
  assign w_idle       = (r_state == IDLE) && rst_n;
  assign w_owner_req  = r_owner_vld && req_valid[r_owner];
  assign w_owner_drop = w_idle && r_owner_vld && !req_valid[r_owner];
  // An owner dropping its request releases the lock, so search starts just past it
  assign w_pick_ptr   = r_owner_vld ? f_next(r_owner) : r_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (w_pick_ptr),
    .o_grant (w_rr_grant),
    .o_any   (w_rr_any)
  );

  // Live lock owner wins outright; everyone else goes through round-robin
  always_comb begin
    w_grant = '0;
    if (w_idle) begin
      w_grant = w_owner_req ? (NUM_REQ'(1) << r_owner) : (w_rr_any ? w_rr_grant : '0);
    end
  end

  // Select the granted requester's index, address and access flags
  always_comb begin
    w_gidx = '0;
    w_row  = '0;
    w_col  = '0;
    w_lock = 1'b0;
    w_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx = PTR_W'(i);
        w_row  = req_row[i*ADDR_W +: ADDR_W];
        w_col  = req_col[i*ADDR_W +: ADDR_W];
        w_lock = req_lock[i];
        w_we   = req_we[i];
      end
    end
  end

  assign w_accept   = |w_grant;
  assign w_hold_nxt = (w_owner_req ? r_hold : '0) + 1'b1;
  assign w_forced   = w_accept && w_lock && (w_hold_nxt == HOLD_W'(MAX_HOLD));
  assign req_ready  = w_grant;

  // Access sequencer: accept, strobe memory, capture read data, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
      r_hold      <= '0;
      r_we        <= 1'b0;
      r_gnt       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_oe        <= 1'b0;
      r_mwe       <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= 1'b0;
    end else begin
      r_oe        <= 1'b0;
      r_mwe       <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_owner_drop) begin
            r_owner_vld <= 1'b0;
            r_hold      <= '0;
            r_ptr       <= f_next(r_owner);
          end
          if (w_accept) begin
            r_row   <= w_row;
            r_col   <= w_col;
            r_we    <= w_we;
            r_oe    <= !w_we;
            r_mwe   <= w_we;
            r_gnt   <= w_grant;
            r_state <= ISSUE;
            if (w_lock && !w_forced) begin
              r_owner_vld <= 1'b1;
              r_owner     <= w_gidx;
              r_hold      <= w_hold_nxt;
            end else begin
              r_owner_vld <= 1'b0;
              r_hold      <= '0;
              r_ptr       <= f_next(w_gidx);
            end
          end
        end
        ISSUE: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_rsp_valid <= r_gnt;
          r_rsp_data  <= !r_we && maze_in;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign row       = r_row;
  assign col       = r_col;
  assign maze_oe   = r_oe;
  assign maze_we   = r_mwe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

`ifdef MAZE_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] r_stat_grants;
  logic [15:0]           r_stat_conflicts;
  logic [15:0]           r_stat_forced;
  logic [3:0]            w_nvalid;

  // Number of requesters contending this cycle
  always_comb begin
    w_nvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_nvalid = w_nvalid + 4'(req_valid[i]);
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_grants    <= '0;
      r_stat_conflicts <= '0;
      r_stat_forced    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && r_stat_grants[i*16 +: 16] != 16'hFFFF) begin
          r_stat_grants[i*16 +: 16] <= r_stat_grants[i*16 +: 16] + 16'd1;
        end
      end
      if (w_idle && w_nvalid >= 4'd2 && r_stat_conflicts != 16'hFFFF) begin
        r_stat_conflicts <= r_stat_conflicts + 16'd1;
      end
      if (w_forced && r_stat_forced != 16'hFFFF) begin
        r_stat_forced <= r_stat_forced + 16'd1;
      end
    end
  end

  assign stat_grants    = r_stat_grants;
  assign stat_conflicts = r_stat_conflicts;
  assign stat_forced    = r_stat_forced;
`endif

endmodule
